// File: rtl/mem_access_stage.sv
// MEM stage: LB/LH/LW(U) and SB/SH/SW against internal little-endian memory, 1-cycle MEM/WB register, no stall or backpressure.
// Optional MEM_DEBUG_PORT_EN adds a side-effect-free combinational debug word read port (dbg_addr/dbg_word).
module mem_access_stage #(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     mem_alu_result,
  input  logic [31:0]           mem_write_data,
  input  logic                  mem_mem_read,
  input  logic                  mem_mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] mem_write_register,
  input  logic                  mem_halt,
  output logic [31:0]           mem_read_data,
  output logic [31:0]           wb_read_data,
  output logic [ADDR_W-1:0]     wb_alu_result,
  output logic [REG_ADDR_W-1:0] wb_write_register,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic                  wb_halt,
`ifdef MEM_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [31:0]           dbg_word,
`endif
  output logic                  misalign_error
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [31:0] mem_q [MEM_DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             misaligned;
  logic             store_en;
  logic [3:0]       be;
  logic [31:0]      wdat;
  logic [31:0]      rd_word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_ext;

  // Upper address bits only select among aliases of the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_alu_result[ADDR_W-1:IDX_W+2];

  assign word_idx = mem_alu_result[IDX_W+1:2];
  assign lane     = mem_alu_result[1:0];
  assign rd_word  = mem_q[word_idx];

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wdat       = mem_write_data;
    byte_v     = rd_word[7:0];
    half_v     = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext   = rd_word;

    case (lane)
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase

    case (mem_size)
      2'b00: begin
        be       = 4'b0001 << lane;
        wdat     = {4{mem_write_data[7:0]}};
        load_ext = mem_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      2'b01: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdat       = {2{mem_write_data[15:0]}};
        load_ext   = mem_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: begin
        misaligned = (lane != 2'b00);
        be         = 4'b1111;
        load_ext   = rd_word;
      end
    endcase

    misaligned    = misaligned && (mem_mem_read || mem_mem_write);
    store_en      = mem_mem_write && !misaligned && !reset;
    mem_read_data = (mem_mem_read && !misaligned) ? load_ext : 32'b0;
  end

  // Memory is never cleared; only the enabled byte lanes of the word change.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  logic unused_dbg_bits;
  assign unused_dbg_bits = ^{dbg_addr[ADDR_W-1:IDX_W+2], dbg_addr[1:0]};
  assign dbg_word        = mem_q[dbg_addr[IDX_W+1:2]];
`endif

  logic [31:0]           wb_read_data_d,      wb_read_data_q;
  logic [ADDR_W-1:0]     wb_alu_result_d,     wb_alu_result_q;
  logic [REG_ADDR_W-1:0] wb_write_register_d, wb_write_register_q;
  logic                  wb_reg_write_d,      wb_reg_write_q;
  logic                  wb_mem_to_reg_d,     wb_mem_to_reg_q;
  logic                  wb_halt_d,           wb_halt_q;
  logic                  misalign_error_d,    misalign_error_q;

  always_comb begin
    wb_read_data_d      = mem_read_data;
    wb_alu_result_d     = mem_alu_result;
    wb_write_register_d = mem_write_register;
    wb_reg_write_d      = mem_reg_write && !misaligned;
    wb_mem_to_reg_d     = mem_mem_to_reg;
    wb_halt_d           = mem_halt;
    misalign_error_d    = misalign_error_q || misaligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_read_data_q      <= '0;
      wb_alu_result_q     <= '0;
      wb_write_register_q <= '0;
      wb_reg_write_q      <= 1'b0;
      wb_mem_to_reg_q     <= 1'b0;
      wb_halt_q           <= 1'b0;
      misalign_error_q    <= 1'b0;
    end else begin
      wb_read_data_q      <= wb_read_data_d;
      wb_alu_result_q     <= wb_alu_result_d;
      wb_write_register_q <= wb_write_register_d;
      wb_reg_write_q      <= wb_reg_write_d;
      wb_mem_to_reg_q     <= wb_mem_to_reg_d;
      wb_halt_q           <= wb_halt_d;
      misalign_error_q    <= misalign_error_d;
    end
  end

  assign wb_read_data      = wb_read_data_q;
  assign wb_alu_result     = wb_alu_result_q;
  assign wb_write_register = wb_write_register_q;
  assign wb_reg_write      = wb_reg_write_q;
  assign wb_mem_to_reg     = wb_mem_to_reg_q;
  assign wb_halt           = wb_halt_q;
  assign misalign_error    = misalign_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads/stores, extension, misalignment, async reset, address wrap.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic [4:0]  mem_write_register;
  logic        mem_halt;
  logic [31:0] mem_read_data;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_write_register;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        wb_halt;
  logic        misalign_error;
`ifdef MEM_DEBUG_PORT_EN
  logic [31:0] dbg_addr;
  logic [31:0] dbg_word;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.MEM_DEPTH(256), .ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_alu_result     (mem_alu_result),
    .mem_write_data     (mem_write_data),
    .mem_mem_read       (mem_mem_read),
    .mem_mem_write      (mem_mem_write),
    .mem_size           (mem_size),
    .mem_unsigned       (mem_unsigned),
    .mem_reg_write      (mem_reg_write),
    .mem_mem_to_reg     (mem_mem_to_reg),
    .mem_write_register (mem_write_register),
    .mem_halt           (mem_halt),
    .mem_read_data      (mem_read_data),
    .wb_read_data       (wb_read_data),
    .wb_alu_result      (wb_alu_result),
    .wb_write_register  (wb_write_register),
    .wb_reg_write       (wb_reg_write),
    .wb_mem_to_reg      (wb_mem_to_reg),
    .wb_halt            (wb_halt),
`ifdef MEM_DEBUG_PORT_EN
    .dbg_addr           (dbg_addr),
    .dbg_word           (dbg_word),
`endif
    .misalign_error     (misalign_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                    input logic m2r, input logic [4:0] wreg, input logic hlt);
    mem_mem_read       = rd;
    mem_mem_write      = wr;
    mem_size           = sz;
    mem_unsigned       = uns;
    mem_alu_result     = addr;
    mem_write_data     = wd;
    mem_reg_write      = rw;
    mem_mem_to_reg     = m2r;
    mem_write_register = wreg;
    mem_halt           = hlt;
  endtask

  task automatic bubble();
    op(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load helper: apply, step, check registered data one cycle later.
  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
    op(1, 0, sz, uns, addr, 32'h0, 1, 1, 5'd9, 0);
    step();
    chk(tag, wb_read_data, exp);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    op(0, 1, sz, 0, addr, wd, 0, 0, 5'd0, 0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    bubble();
`ifdef MEM_DEBUG_PORT_EN
    dbg_addr = 32'h0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_read_data", wb_read_data, 32'h0);
    chk("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_error}, 32'h0);
    reset = 1'b0;

    // Byte store/load with sign and zero extension
    store(2'b10, 32'h0, 32'h0000_0000);
    store(2'b00, 32'h0, 32'h0000_00FF);
    load("lb_0", 2'b00, 0, 32'h0, 32'hFFFF_FFFF);
    chk("lb_wb_reg_write", {31'b0, wb_reg_write}, 32'h1);
    chk("lb_wb_write_reg", {27'b0, wb_write_register}, 32'd9);
    chk("lb_wb_alu", wb_alu_result, 32'h0);
    load("lbu_0", 2'b00, 1, 32'h0, 32'h0000_00FF);

    // Halfword: only upper two lanes of word 1 change
    store(2'b10, 32'h4, 32'h1122_3344);
    store(2'b01, 32'h6, 32'h0000_CFC7);
    chk("sh_word1", dut.mem_q[1], 32'hCFC7_3344);
    load("lh_6", 2'b01, 0, 32'h6, 32'hFFFF_CFC7);
    load("lhu_6", 2'b01, 1, 32'h6, 32'h0000_CFC7);

    // Word store then immediate loads
    store(2'b10, 32'h8, 32'h0000_5678);
    load("lw_8", 2'b10, 0, 32'h8, 32'h0000_5678);
    load("lwu_8", 2'b11, 1, 32'h8, 32'h0000_5678);
    store(2'b00, 32'h9, 32'h0000_00FE);
    load("lw_8_after_sb", 2'b10, 0, 32'h8, 32'h0000_FE78);
    load("lb_9", 2'b00, 0, 32'h9, 32'hFFFF_FFFE);

`ifdef MEM_DEBUG_PORT_EN
    dbg_addr = 32'hB;
    #1;
    chk("dbg_word", dbg_word, 32'h0000_FE78);
`endif

    // Misaligned halfword load
    chk("misalign_pre", {31'b0, misalign_error}, 32'h0);
    op(1, 0, 2'b01, 0, 32'h3, 32'h0, 1, 1, 5'd4, 0);
    #1;
    chk("misalign_comb_data", mem_read_data, 32'h0);
    step();
    chk("misalign_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    chk("misalign_wb_data", wb_read_data, 32'h0);
    chk("misalign_set", {31'b0, misalign_error}, 32'h1);
    bubble();
    step();
    chk("misalign_sticky", {31'b0, misalign_error}, 32'h1);
    store(2'b10, 32'h2, 32'hAAAA_AAAA);
    chk("misalign_sw_word0", dut.mem_q[0], 32'h0000_00FF);

    // Simultaneous read and write: read sees old data
    store(2'b10, 32'hC, 32'h0102_0304);
    op(1, 1, 2'b10, 0, 32'hC, 32'h5566_7788, 1, 1, 5'd3, 0);
    #1;
    chk("rw_comb_old", mem_read_data, 32'h0102_0304);
    step();
    chk("rw_wb_old", wb_read_data, 32'h0102_0304);
    chk("rw_mem_new", dut.mem_q[3], 32'h5566_7788);

    // Halt marker and bubble
    op(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 5'd0, 1);
    step();
    chk("halt_set", {31'b0, wb_halt}, 32'h1);
    bubble();
    step();
    chk("halt_clr", {31'b0, wb_halt}, 32'h0);
    chk("bubble_data", wb_read_data, 32'h0);
    chk("bubble_m2r", {31'b0, wb_mem_to_reg}, 32'h0);

    // Address wrap
    store(2'b10, 32'h400, 32'hDEAD_BEEF);
    load("wrap_lw_0", 2'b10, 0, 32'h0, 32'hDEAD_BEEF);

    // Async reset mid-load
    load("pre_rst_lw", 2'b10, 0, 32'hC, 32'h5566_7788);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_wb_data", wb_read_data, 32'h0);
    chk("arst_wb_alu", wb_alu_result, 32'h0);
    chk("arst_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    chk("arst_wb_m2r", {31'b0, wb_mem_to_reg}, 32'h0);
    chk("arst_wb_wreg", {27'b0, wb_write_register}, 32'h0);
    chk("arst_misalign", {31'b0, misalign_error}, 32'h0);
    step();
    reset = 1'b0;
    chk("persist_word3", dut.mem_q[3], 32'h5566_7788);
    load("persist_lw_0", 2'b10, 0, 32'h0, 32'hDEAD_BEEF);
    chk("post_rst_misalign", {31'b0, misalign_error}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
